// File: rtl/i2c_master_cmd.sv
// Single-master I2C initiator: one 8-bit-sub-address register write or read per command.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on scl_in.
module i2c_master_cmd #(
    parameter int unsigned CLK_DIV = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_slave_addr,
    input  logic [7:0] cmd_sub_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    input  logic       scl_in,
    output logic       scl_oe,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe
);
    localparam int unsigned QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QLast = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StSlaW,
        StSub,
        StWdata,
        StRstart,
        StSlaR,
        StRdata,
        StStop,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [QW-1:0] qcnt_q;
    logic [1:0]    phase_q;
    logic [3:0]    bit_q;
    logic          rw_q;
    logic [6:0]    addr_q;
    logic [7:0]    sub_q;
    logic [7:0]    wdata_q;
    logic [7:0]    shift_q;
    logic          rx_bit_q;
    logic          nack_q;
    logic [7:0]    rsp_rdata_q;
    logic          rsp_nack_q;
    logic          sda_s1_q, sda_s2_q;

    logic       hold;
    logic       q_end;
    logic       bit_end;
    logic       ack_end;
    logic       sample;
    logic [7:0] tx_byte;

`ifdef I2C_CLK_STRETCH_EN
    logic scl_s1_q, scl_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_in;
            scl_s2_q <= scl_s1_q;
        end
    end

    // Freeze the bit clock while SCL is released but still seen low (stretch or sync lag).
    assign hold = !scl_oe && !scl_s2_q && (state_q != StIdle) && (state_q != StDone);
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold = 1'b0;
`endif

    assign q_end   = (qcnt_q == QLast) && !hold;
    assign bit_end = q_end && (phase_q == 2'd3);
    assign sample  = q_end && (phase_q == 2'd2);
    assign ack_end = bit_end && (bit_q == 4'd8);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_valid) state_d = StStart;
            StStart:  if (bit_end) state_d = StSlaW;
            StSlaW:   if (ack_end) state_d = rx_bit_q ? StStop : StSub;
            StSub: begin
                if (ack_end) begin
                    if (rx_bit_q)  state_d = StStop;
                    else if (rw_q) state_d = StRstart;
                    else           state_d = StWdata;
                end
            end
            StWdata:  if (ack_end) state_d = StStop;
            StRstart: if (bit_end) state_d = StSlaR;
            StSlaR:   if (ack_end) state_d = rx_bit_q ? StStop : StRdata;
            StRdata:  if (ack_end) state_d = StStop;
            StStop:   if (bit_end) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        unique case (state_q)
            StSlaW:  tx_byte = {addr_q, 1'b0};
            StSub:   tx_byte = sub_q;
            StWdata: tx_byte = wdata_q;
            StSlaR:  tx_byte = {addr_q, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            StStart: sda_oe = phase_q[1];
            StSlaW, StSub, StWdata, StSlaR: begin
                scl_oe = !phase_q[1];
                sda_oe = (bit_q < 4'd8) && !tx_byte[3'd7 - bit_q[2:0]];
            end
            StRdata: scl_oe = !phase_q[1];
            StRstart: begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = phase_q[1];
            end
            StStop: begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = !phase_q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qcnt_q      <= '0;
            phase_q     <= 2'd0;
            bit_q       <= 4'd0;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            sub_q       <= 8'd0;
            wdata_q     <= 8'd0;
            shift_q     <= 8'd0;
            rx_bit_q    <= 1'b1;
            nack_q      <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_nack_q  <= 1'b0;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
        end else begin
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
            if (state_q == StIdle) begin
                qcnt_q  <= '0;
                phase_q <= 2'd0;
                bit_q   <= 4'd0;
                if (cmd_valid) begin
                    rw_q    <= cmd_rw;
                    addr_q  <= cmd_slave_addr;
                    sub_q   <= cmd_sub_addr;
                    wdata_q <= cmd_wdata;
                    shift_q <= 8'd0;
                    nack_q  <= 1'b0;
                end
            end else begin
                if (!hold) qcnt_q <= (qcnt_q == QLast) ? '0 : qcnt_q + QW'(1);
                if (q_end) phase_q <= phase_q + 2'd1;
                if (state_d != state_q) bit_q <= 4'd0;
                else if (bit_end)       bit_q <= bit_q + 4'd1;
                if (sample) begin
                    rx_bit_q <= sda_s2_q;
                    if (state_q == StRdata && bit_q < 4'd8) shift_q <= {shift_q[6:0], sda_s2_q};
                end
                if (ack_end && rx_bit_q &&
                    (state_q == StSlaW || state_q == StSub ||
                     state_q == StWdata || state_q == StSlaR)) begin
                    nack_q <= 1'b1;
                end
                if (state_q == StStop && state_d == StDone) begin
                    rsp_nack_q  <= nack_q;
                    rsp_rdata_q <= (rw_q && !nack_q) ? shift_q : 8'd0;
                end
            end
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;
    assign sda_out   = 1'b0;

endmodule

// File: tb/tb_i2c_master_cmd.sv
// Randomised bench for i2c_master_cmd: a bus-level I2C slave model plus a transaction-level
// reference of expected bytes, response and latency. Honours I2C_CLK_STRETCH_EN.
module tb_i2c_master_cmd;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned P = 4 * CLK_DIV;
    localparam logic [6:0] SlvAddr = 7'h30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_slave_addr = 7'd0;
    logic [7:0] cmd_sub_addr = 8'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl_oe, sda_oe, sda_out;
    logic       scl_line, sda_line;

    logic       slv_drv = 1'b0;
    int         stretch_cnt = 0;
    logic       nack_data_req = 1'b0;
    logic       stretch_req = 1'b0;
    logic [8:0] slv_log[$];
    logic [7:0] slv_mem[256];
    logic [7:0] ref_mem[256];

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    assign scl_line = !scl_oe && (stretch_cnt == 0);
    assign sda_line = !sda_oe && !slv_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_master_cmd #(.CLK_DIV(CLK_DIV)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rw         (cmd_rw),
        .cmd_slave_addr (cmd_slave_addr),
        .cmd_sub_addr   (cmd_sub_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_nack       (rsp_nack),
        .busy           (busy),
        .scl_in         (scl_line),
        .scl_oe         (scl_oe),
        .sda_in         (sda_line),
        .sda_out        (sda_out),
        .sda_oe         (sda_oe)
    );

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 91) ^ 8'hA3;
        if (i == 2) v = 8'h3C;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle-sampled I2C slave at SlvAddr: START/STOP detect, ACK, register pointer, read data.
    initial begin : slave
        logic scl, sda, scl_p, sda_p, active, tx, tx_pend, nacked, ack;
        logic [7:0] shreg, txb, ptr;
        int bitpos, byte_no;
        for (int i = 0; i < 256; i++) slv_mem[i] = init_val(i);
        scl_p = 1'b1; sda_p = 1'b1; active = 1'b0; tx = 1'b0; tx_pend = 1'b0;
        nacked = 1'b0; ack = 1'b0; shreg = 8'd0; txb = 8'd0; ptr = 8'd0;
        bitpos = 0; byte_no = 0;
        forever begin
            @(negedge clk);
            scl = scl_line;
            sda = sda_line;
            if (stretch_cnt > 0) stretch_cnt = stretch_cnt - 1;
            if (reset) begin
                active = 1'b0; tx = 1'b0; tx_pend = 1'b0; slv_drv = 1'b0; stretch_cnt = 0;
            end else if (scl_p && scl && sda_p && !sda) begin
                slv_log.push_back(9'h100);
                active = 1'b1; bitpos = 0; byte_no = 0; tx = 1'b0; tx_pend = 1'b0;
                nacked = 1'b0; slv_drv = 1'b0;
            end else if (scl_p && scl && !sda_p && sda) begin
                slv_log.push_back(9'h101);
                active = 1'b0; tx = 1'b0; slv_drv = 1'b0;
            end else if (active && !scl_p && scl) begin
                if (!tx && bitpos < 8) shreg = {shreg[6:0], sda};
                bitpos++;
            end else if (active && scl_p && !scl) begin
                if (bitpos == 8) begin
                    if (tx) slv_drv = 1'b0;
                    else begin
                        slv_log.push_back({1'b0, shreg});
                        if (byte_no == 0) begin
                            ack = (shreg[7:1] == SlvAddr);
                            tx_pend = ack && shreg[0];
                        end else if (byte_no == 1) begin
                            ack = 1'b1;
                            ptr = shreg;
                        end else begin
                            ack = !nack_data_req;
                            if (ack) slv_mem[ptr] = shreg;
                        end
                        nacked = !ack;
                        slv_drv = ack;
                        byte_no++;
                    end
                end else if (bitpos == 9) begin
                    slv_drv = 1'b0;
                    bitpos = 0;
                    if (nacked || tx) begin
                        active = 1'b0; tx = 1'b0;
                    end else if (tx_pend) begin
                        tx = 1'b1; tx_pend = 1'b0;
                        txb = slv_mem[ptr];
                        slv_drv = !txb[7];
                    end
                end else if (tx) begin
                    slv_drv = !txb[7 - bitpos];
                    if (bitpos == 1 && stretch_req) stretch_cnt = 50;
                end
            end
            scl_p = scl;
            sda_p = sda;
        end
    end

    task automatic run_cmd(input logic rw, input logic [6:0] a, input logic [7:0] s,
                           input logic [7:0] d, input logic dnack, input logic stretch);
        logic [8:0] exp_log[$];
        logic       exp_nack, got;
        logic [7:0] exp_rdata;
        int unsigned t0, lat, base, periods;
        int lbase;

        exp_log.push_back(9'h100);
        exp_log.push_back({1'b0, a, 1'b0});
        if (a != SlvAddr) begin
            exp_nack = 1'b1;
            periods = 11;
        end else begin
            exp_log.push_back({1'b0, s});
            if (!rw) begin
                exp_log.push_back({1'b0, d});
                exp_nack = dnack;
                periods = 29;
            end else begin
                exp_log.push_back(9'h100);
                exp_log.push_back({1'b0, a, 1'b1});
                exp_nack = 1'b0;
                periods = 39;
            end
        end
        exp_log.push_back(9'h101);
        exp_rdata = (rw && !exp_nack) ? ref_mem[s] : 8'h00;
        base = 1 + periods * P;

        lbase = slv_log.size();
        nack_data_req = dnack;
        stretch_req = stretch;
        @(posedge clk); #1;
        cmd_rw = rw; cmd_slave_addr = a; cmd_sub_addr = s; cmd_wdata = d; cmd_valid = 1'b1;
        @(negedge clk);
        check_eq("accept_ready", cmd_ready, 1'b1);
        t0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_rw = 1'($urandom); cmd_slave_addr = 7'($urandom);
        cmd_sub_addr = 8'($urandom); cmd_wdata = 8'($urandom);
        @(negedge clk);
        check_eq("busy_start", busy, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rsp_seen", got, 1'b1);
        lat = cyc - t0;
`ifdef I2C_CLK_STRETCH_EN
        if (stretch) check_eq("lat_stretch", lat >= base + 50, 1'b1);
        else         check_eq("lat_range", (lat >= base) && (lat <= base + 80), 1'b1);
`else
        check_eq("latency", lat, base);
`endif
        check_eq("rsp_nack", rsp_nack, exp_nack);
        check_eq("rsp_rdata", rsp_rdata, exp_rdata);
        check_eq("busy_done", busy, 1'b1);
        check_eq("ready_done", cmd_ready, 1'b0);
        @(negedge clk);
        check_eq("ready_after", cmd_ready, 1'b1);
        check_eq("busy_after", busy, 1'b0);
        check_eq("pulse_width", rsp_valid, 1'b0);
        check_eq("hold_rdata", rsp_rdata, exp_rdata);
        check_eq("log_len", slv_log.size() - lbase, exp_log.size());
        for (int i = 0; i < exp_log.size() && lbase + i < slv_log.size(); i++)
            check_eq("log_byte", slv_log[lbase + i], exp_log[i]);
        if (!rw && !exp_nack) ref_mem[s] = d;
        nack_data_req = 1'b0;
        stretch_req = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int unsigned t0, target;
        logic seen;
        logic rw, dn;
        logic [6:0] a;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", cmd_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rdata", rsp_rdata, 8'h00);
        check_eq("rst_nack", rsp_nack, 1'b0);
        check_eq("rst_scl_oe", scl_oe, 1'b0);
        check_eq("rst_sda_oe", sda_oe, 1'b0);
        check_eq("rst_sda_out", sda_out, 1'b0);

        run_cmd(1'b0, SlvAddr, 8'h05, 8'hA7, 1'b0, 1'b0);
        run_cmd(1'b1, SlvAddr, 8'h02, 8'h00, 1'b0, 1'b0);
        run_cmd(1'b1, SlvAddr, 8'h05, 8'h00, 1'b0, 1'b0);
        run_cmd(1'b0, 7'h31,   8'h05, 8'h11, 1'b0, 1'b0);
        run_cmd(1'b0, SlvAddr, 8'h10, 8'h55, 1'b1, 1'b0);
        run_cmd(1'b0, SlvAddr, 8'h11, 8'h66, 1'b0, 1'b0);
        run_cmd(1'b1, SlvAddr, 8'h11, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of SUB bit 3.
        @(posedge clk); #1;
        cmd_rw = 1'b0; cmd_slave_addr = SlvAddr; cmd_sub_addr = 8'h20; cmd_wdata = 8'h99;
        cmd_valid = 1'b1;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        target = t0 + 1 + 13 * P + 5;
        while (cyc < target) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_busy", busy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mrst_scl_oe", scl_oe, 1'b0);
        check_eq("mrst_sda_oe", sda_oe, 1'b0);
        check_eq("mrst_ready", cmd_ready, 1'b1);
        check_eq("mrst_rsp_valid", rsp_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("mrst_no_rsp", seen, 1'b0);

        for (int n = 0; n < 16; n++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == SlvAddr) a = 7'h2F;
            end else begin
                a = SlvAddr;
            end
            dn = !rw && ($urandom_range(0, 5) == 0);
            run_cmd(rw, a, 8'($urandom), 8'($urandom), dn, 1'b0);
        end

`ifdef I2C_CLK_STRETCH_EN
        run_cmd(1'b1, SlvAddr, 8'h02, 8'h00, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
